// File: rtl/ad_ip_jesd204_tpl_adc_cfg_seq.sv
// TPL ADC profile apply sequencer: reset assert, profile write, reset release, status poll.
// Define TPL_ADC_CFG_SEQ_READBACK_EN to add a PROF_RD readback check after PROF_WR.
module ad_ip_jesd204_tpl_adc_cfg_seq #(
   parameter int ADDRESS_WIDTH = 10,
   parameter int NUM_PROFILES = 1,
   parameter logic [ADDRESS_WIDTH-1:0] RSTN_ADDR = 'h010,
   parameter logic [ADDRESS_WIDTH-1:0] STATUS_ADDR = 'h017,
   parameter logic [ADDRESS_WIDTH-1:0] PROFILE_ADDR = 'h090,
   parameter int POLL_LIMIT = 1024,
   parameter int ACK_LIMIT = 64
) (
   input  logic up_clk,
   input  logic up_rstn,
   input  logic start,
   input  logic [$clog2(NUM_PROFILES):0] profile,
   output logic busy,
   output logic done,
   output logic error,
   output logic up_wreq,
   output logic [ADDRESS_WIDTH-1:0] up_waddr,
   output logic [31:0] up_wdata,
   input  logic up_wack,
   output logic up_rreq,
   output logic [ADDRESS_WIDTH-1:0] up_raddr,
   input  logic [31:0] up_rdata,
   input  logic up_rack
);

   localparam int PW = $clog2(NUM_PROFILES) + 1;
   localparam int AW5 = $clog2(ACK_LIMIT + 1);
   localparam int CW = (AW5 > 5) ? AW5 : 5;
   localparam int NW = $clog2(POLL_LIMIT + 1);
   localparam logic [31:0] NP = NUM_PROFILES;

   typedef enum logic [3:0] {
      IDLE,
      RST_ASSERT,
      PROF_WR,
`ifdef TPL_ADC_CFG_SEQ_READBACK_EN
      PROF_RD,
`endif
      RST_RELEASE,
      POLL_RD,
      POLL_WAIT,
      DONE,
      ERR
   } state_t;

   state_t r_state, w_state_nxt;
   logic [PW-1:0] r_profile, w_profile_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [NW-1:0] r_poll, w_poll_nxt;
   logic r_pend, w_pend_nxt;
   logic r_error, w_error_nxt;

   logic [31:0] w_prof_ext;
   logic w_prof_ok;
   logic w_wr;
   logic w_rd;
   logic w_ack;
   logic w_acc_done;
   logic w_ack_to;

   assign w_prof_ext = {{(32-PW){1'b0}}, r_profile};
   assign w_prof_ok = (w_prof_ext < NP);

   // an invalid profile parks in RST_ASSERT for one cycle without touching the bus
   always_comb begin
      w_wr = 1'b0;
      w_rd = 1'b0;
      unique case (r_state)
         RST_ASSERT:  w_wr = w_prof_ok;
         PROF_WR:     w_wr = 1'b1;
         RST_RELEASE: w_wr = 1'b1;
         POLL_RD:     w_rd = 1'b1;
`ifdef TPL_ADC_CFG_SEQ_READBACK_EN
         PROF_RD:     w_rd = 1'b1;
`endif
         default:     ;
      endcase
   end

   assign w_ack = (w_wr & up_wack) | (w_rd & up_rack);
   assign w_acc_done = r_pend & w_ack;
   assign w_ack_to = r_pend & ~w_ack &
                     (r_cnt == CW'(ACK_LIMIT - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_profile_nxt = r_profile;
      w_cnt_nxt = r_cnt;
      w_poll_nxt = r_poll;
      w_pend_nxt = r_pend;
      w_error_nxt = r_error;

      // shared request/acknowledge handshake for every bus access
      if (w_wr | w_rd) begin
         if (!r_pend) begin
            w_pend_nxt = 1'b1;
            w_cnt_nxt = CW'(1);
         end else if (w_ack) begin
            w_pend_nxt = 1'b0;
         end else if (w_ack_to) begin
            w_pend_nxt = 1'b0;
            w_state_nxt = ERR;
         end else begin
            w_cnt_nxt = r_cnt + 1'b1;
         end
      end

      unique case (r_state)
         IDLE: begin
            w_poll_nxt = '0;
            if (start) begin
               w_profile_nxt = profile;
               w_error_nxt = 1'b0;
               w_state_nxt = RST_ASSERT;
            end
         end
         RST_ASSERT: begin
            if (!w_prof_ok)
               w_state_nxt = ERR;
            else if (w_acc_done)
               w_state_nxt = PROF_WR;
         end
         PROF_WR: begin
            if (w_acc_done)
`ifdef TPL_ADC_CFG_SEQ_READBACK_EN
               w_state_nxt = PROF_RD;
`else
               w_state_nxt = RST_RELEASE;
`endif
         end
`ifdef TPL_ADC_CFG_SEQ_READBACK_EN
         PROF_RD: begin
            if (w_acc_done)
               w_state_nxt = (up_rdata == w_prof_ext) ?
                             RST_RELEASE : ERR;
         end
`endif
         RST_RELEASE: begin
            if (w_acc_done)
               w_state_nxt = POLL_RD;
         end
         POLL_RD: begin
            if (w_acc_done) begin
               if (up_rdata[0]) begin
                  w_state_nxt = DONE;
               end else if (r_poll == NW'(POLL_LIMIT - 1)) begin
                  w_state_nxt = ERR;
               end else begin
                  w_poll_nxt = r_poll + 1'b1;
                  w_cnt_nxt = '0;
                  w_state_nxt = POLL_WAIT;
               end
            end
         end
         POLL_WAIT: begin
            if (r_cnt == CW'(15))
               w_state_nxt = POLL_RD;
            else
               w_cnt_nxt = r_cnt + 1'b1;
         end
         DONE:    w_state_nxt = IDLE;
         ERR:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase

      if (w_state_nxt == ERR)
         w_error_nxt = 1'b1;
   end

   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         r_state <= IDLE;
         r_profile <= '0;
         r_cnt <= '0;
         r_poll <= '0;
         r_pend <= 1'b0;
         r_error <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_profile <= w_profile_nxt;
         r_cnt <= w_cnt_nxt;
         r_poll <= w_poll_nxt;
         r_pend <= w_pend_nxt;
         r_error <= w_error_nxt;
      end
   end

   assign busy = (r_state != IDLE);
   assign done = (r_state == DONE);
   assign error = r_error;
   assign up_wreq = w_wr & ~r_pend;
   assign up_rreq = w_rd & ~r_pend;

   // address/data are decoded from state so they hold until the acknowledge
   always_comb begin
      up_waddr = '0;
      up_wdata = '0;
      up_raddr = '0;
      unique case (r_state)
         RST_ASSERT: begin
            if (w_prof_ok)
               up_waddr = RSTN_ADDR;
         end
         PROF_WR: begin
            up_waddr = PROFILE_ADDR;
            up_wdata = w_prof_ext;
         end
         RST_RELEASE: begin
            up_waddr = RSTN_ADDR;
            up_wdata = 32'h3;
         end
         POLL_RD: up_raddr = STATUS_ADDR;
`ifdef TPL_ADC_CFG_SEQ_READBACK_EN
         PROF_RD: up_raddr = PROFILE_ADDR;
`endif
         default: ;
      endcase
   end

`ifndef TPL_ADC_CFG_SEQ_READBACK_EN
   logic w_unused_rdata;
   assign w_unused_rdata = ^up_rdata[31:1];
`endif

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_cfg_seq.sv
// Directed bench for ad_ip_jesd204_tpl_adc_cfg_seq with a 2-cycle up-bus responder.
// Also covers the readback path when TPL_ADC_CFG_SEQ_READBACK_EN is defined.
`timescale 1ns/1ps
module tb_ad_ip_jesd204_tpl_adc_cfg_seq;

   localparam int AL = 8;
`ifdef TPL_ADC_CFG_SEQ_READBACK_EN
   localparam int RB = 1;
`else
   localparam int RB = 0;
`endif

   logic up_clk = 1'b0;
   logic up_rstn;
   logic start;
   logic [1:0] profile;
   logic busy, done, error;
   logic up_wreq, up_rreq;
   logic [9:0] up_waddr, up_raddr;
   logic [31:0] up_wdata;
   logic [31:0] up_rdata = '0;
   wire up_wack, up_rack;
   logic r_wack = 1'b0;
   logic r_rack = 1'b0;
   logic stray;

   assign up_wack = r_wack | stray;
   assign up_rack = r_rack | stray;

   ad_ip_jesd204_tpl_adc_cfg_seq #(
      .ADDRESS_WIDTH(10),
      .NUM_PROFILES(2),
      .POLL_LIMIT(4),
      .ACK_LIMIT(AL)
   ) dut (
      .up_clk(up_clk),
      .up_rstn(up_rstn),
      .start(start),
      .profile(profile),
      .busy(busy),
      .done(done),
      .error(error),
      .up_wreq(up_wreq),
      .up_waddr(up_waddr),
      .up_wdata(up_wdata),
      .up_wack(up_wack),
      .up_rreq(up_rreq),
      .up_raddr(up_raddr),
      .up_rdata(up_rdata),
      .up_rack(up_rack)
   );

   always #5 up_clk = ~up_clk;

   logic clr;
   int zero_rd, hold_w, rb_bad;
   int cyc = 0, wcnt = 0, rcnt = 0, dcnt = 0;
   int st_rd = 0, wd = 0, rd = 0, err_rise = -1;
   int w_cyc[16];
   int r_cyc[16];
   logic [9:0] w_adr[16];
   logic [31:0] w_dat[16];
   logic [9:0] r_adr[16];
   logic [31:0] prof_mem = '0;
   logic [31:0] r_val = '0;
   logic prev_err = 1'b0;

   // responder acks two cycles after each request; also logs bus activity
   always @(negedge up_clk) begin
      cyc++;
      if (clr) begin
         wcnt = 0; rcnt = 0; dcnt = 0;
         st_rd = 0; err_rise = -1;
      end
      r_wack = 1'b0;
      r_rack = 1'b0;
      if (wd > 0) begin
         wd--;
         if (wd == 0) r_wack = 1'b1;
      end
      if (rd > 0) begin
         rd--;
         if (rd == 0) begin
            r_rack = 1'b1;
            up_rdata = r_val;
         end
      end
      if (up_wreq) begin
         if (wcnt < 16) begin
            w_cyc[wcnt] = cyc;
            w_adr[wcnt] = up_waddr;
            w_dat[wcnt] = up_wdata;
         end
         wcnt++;
         if (wcnt != hold_w) wd = 2;
         if (up_waddr == 10'h090) prof_mem = up_wdata;
      end
      if (up_rreq) begin
         if (rcnt < 16) begin
            r_cyc[rcnt] = cyc;
            r_adr[rcnt] = up_raddr;
         end
         rcnt++;
         if (up_raddr == 10'h017) begin
            st_rd++;
            r_val = (st_rd > zero_rd) ? 32'h1 : 32'h0;
         end else begin
            r_val = (rb_bad != 0) ? 32'h0 : prof_mem;
         end
         rd = 2;
      end
      if (done) dcnt++;
      if (error && !prev_err) err_rise = cyc;
      prev_err = error;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge up_clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) tick();
   endtask

   task automatic clear_log();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      int n = 0;
      while (busy && n < lim) begin
         tick();
         n++;
      end
      chk("idle_bound", {31'b0, busy}, 32'h0);
   endtask

   task automatic go(input logic [1:0] p);
      profile = p;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_busy"}, {31'b0, busy}, 0);
      chk({tag, "_done"}, {31'b0, done}, 0);
      chk({tag, "_err"}, {31'b0, error}, 0);
      chk({tag, "_wreq"}, {31'b0, up_wreq}, 0);
      chk({tag, "_rreq"}, {31'b0, up_rreq}, 0);
      chk({tag, "_waddr"}, {22'b0, up_waddr}, 0);
      chk({tag, "_raddr"}, {22'b0, up_raddr}, 0);
      chk({tag, "_wdata"}, up_wdata, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      up_rstn = 1'b0;
      start = 1'b0;
      profile = 2'd0;
      clr = 1'b0;
      stray = 1'b0;
      zero_rd = 0;
      hold_w = 0;
      rb_bad = 0;
      wait_cycles(3);
      chk_quiet("rst");
      up_rstn = 1'b1;
      tick();

      stray = 1'b1;
      tick();
      stray = 1'b0;
      chk("stray_idle", {31'b0, busy}, 0);

      // nominal apply of profile 1, status ready on first poll
      clear_log();
      profile = 2'd1;
      start = 1'b1;
      chk("busy_pre", {31'b0, busy}, 0);
      tick();
      start = 1'b0;
      chk("busy_rise", {31'b0, busy}, 1);
      wait_idle(300);
      tick();
      chk("t1_wcnt", wcnt, 3);
      chk("t1_wa0", {22'b0, w_adr[0]}, 32'h010);
      chk("t1_wd0", w_dat[0], 32'h0);
      chk("t1_wa1", {22'b0, w_adr[1]}, 32'h090);
      chk("t1_wd1", w_dat[1], 32'h1);
      chk("t1_wa2", {22'b0, w_adr[2]}, 32'h010);
      chk("t1_wd2", w_dat[2], 32'h3);
      chk("t1_wgap", w_cyc[1] - w_cyc[0], 3);
      chk("t1_rcnt", rcnt, 1 + RB);
      chk("t1_ra", {22'b0, r_adr[RB]}, 32'h017);
      chk("t1_done", dcnt, 1);
      chk("t1_err", {31'b0, error}, 0);

      // three not-ready polls, ready on the fourth
      zero_rd = 3;
      clear_log();
      go(2'd1);
      wait_idle(500);
      tick();
      chk("t2_rcnt", rcnt, 4 + RB);
      chk("t2_gap0", r_cyc[RB+1] - r_cyc[RB], 19);
      chk("t2_gap2", r_cyc[RB+3] - r_cyc[RB+2], 19);
      chk("t2_done", dcnt, 1);
      chk("t2_err", {31'b0, error}, 0);

      // status never ready: poll limit of 4
      zero_rd = 100;
      clear_log();
      go(2'd1);
      wait_idle(500);
      tick();
      chk("t3_rcnt", rcnt, 4 + RB);
      chk("t3_err", {31'b0, error}, 1);
      chk("t3_done", dcnt, 0);
      chk("t3_busy", {31'b0, busy}, 0);

      // out-of-range profile: no bus traffic
      zero_rd = 0;
      clear_log();
      go(2'd2);
      chk("t4_errclr", {31'b0, error}, 0);
      wait_idle(50);
      tick();
      chk("t4_wcnt", wcnt, 0);
      chk("t4_rcnt", rcnt, 0);
      chk("t4_err", {31'b0, error}, 1);

      // second write never acknowledged; start while busy ignored
      hold_w = 2;
      clear_log();
      go(2'd1);
      wait_cycles(6);
      go(2'd1);
      wait_idle(200);
      tick();
      chk("t5_to", err_rise - w_cyc[1], AL);
      chk("t5_wcnt", wcnt, 2);
      chk("t5_err", {31'b0, error}, 1);
      chk("t5_done", dcnt, 0);
      hold_w = 0;
      wait_cycles(10);
      chk("t5_nostart", wcnt, 2);
      chk("t5_busy", {31'b0, busy}, 0);

      // reset during POLL_WAIT, then a fresh sequence
      zero_rd = 100;
      clear_log();
      go(2'd1);
      for (int n = 0; n < 100 && rcnt <= RB; n++) tick();
      chk("t6_reached", {31'b0, rcnt > RB}, 1);
      wait_cycles(6);
      chk("t6_inwait", {31'b0, busy}, 1);
      up_rstn = 1'b0;
      #1;
      chk_quiet("t6_rst");
      clear_log();
      wait_cycles(2);
      chk("t6_rst_w", wcnt, 0);
      chk("t6_rst_r", rcnt, 0);
      up_rstn = 1'b1;
      tick();
      zero_rd = 0;
      clear_log();
      go(2'd1);
      wait_idle(300);
      tick();
      chk("t6_wcnt", wcnt, 3);
      chk("t6_rcnt", rcnt, 1 + RB);
      chk("t6_done", dcnt, 1);
      chk("t6_err", {31'b0, error}, 0);

`ifdef TPL_ADC_CFG_SEQ_READBACK_EN
      rb_bad = 1;
      clear_log();
      go(2'd1);
      wait_idle(300);
      tick();
      chk("rb_err", {31'b0, error}, 1);
      chk("rb_wcnt", wcnt, 2);
      chk("rb_done", dcnt, 0);
      rb_bad = 0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ad_ip_jesd204_tpl_adc_cfg_seq.md
AD_IP_JESD204_TPL_ADC_CFG_SEQ -- requirements
Module: ad_ip_jesd204_tpl_adc_cfg_seq

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 10: width of the internal up-bus word address.
REQ-002 Parameter NUM_PROFILES, default 1: number of JESD profiles supported by the TPL ADC.
REQ-003 Parameter RSTN_ADDR, default 10'h010: word address of the ADC common reset register; bit 0 is the ADC reset release.
REQ-004 Parameter STATUS_ADDR, default 10'h017: word address of the ADC common status register; bit 0 is ADC status.
REQ-005 Parameter PROFILE_ADDR, default 10'h090: word address of the TPL profile-select register.
REQ-006 Parameter POLL_LIMIT, default 1024: maximum number of status reads before timeout.
REQ-007 Parameter ACK_LIMIT, default 64: maximum cycles to wait for an up-bus acknowledge.
REQ-008 up_clk  in  1  sole clock.
REQ-009 up_rstn  in  1  asynchronous, active-low reset.
REQ-010 start  in  1  single-cycle request to apply a profile.
REQ-011 profile  in  $clog2(NUM_PROFILES)+1  requested profile index, sampled when start is accepted.
REQ-012 busy  out  1  sequence in progress.
REQ-013 done  out  1  one-cycle pulse on successful completion.
REQ-014 error  out  1  failure flag; stays high until the next accepted start.
REQ-015 up_wreq, up_waddr[ADDRESS_WIDTH-1:0], up_wdata[31:0]  out  write request, address and data; up_wreq is a one-cycle pulse.
REQ-016 up_wack  in  1  write acknowledge.
REQ-017 up_rreq, up_raddr[ADDRESS_WIDTH-1:0]  out  read request and address; up_rreq is a one-cycle pulse.
REQ-018 up_rdata[31:0], up_rack  in  read data, valid in the cycle up_rack is high.

Function
REQ-019 The FSM SHALL use states IDLE, RST_ASSERT, PROF_WR, RST_RELEASE, POLL_RD, POLL_WAIT, DONE and ERR.
REQ-020 In IDLE, start=1 SHALL latch profile, clear error, and enter RST_ASSERT on the next cycle; busy rises in that same next cycle.
REQ-021 If the latched profile is >= NUM_PROFILES, the FSM SHALL go to ERR with no bus access.
REQ-022 RST_ASSERT SHALL pulse a write of 32'h0 to RSTN_ADDR.
REQ-023 PROF_WR SHALL pulse a write of the zero-extended profile to PROFILE_ADDR.
REQ-024 RST_RELEASE SHALL pulse a write of 32'h3 to RSTN_ADDR.
REQ-025 Each bus access SHALL issue exactly one request pulse, then hold until the acknowledge; the next request SHALL be issued no earlier than the cycle after the acknowledge.
REQ-026 If no acknowledge arrives within ACK_LIMIT cycles after the request, the FSM SHALL go to ERR.
REQ-027 POLL_RD SHALL read STATUS_ADDR.
  - up_rdata[0]=1 with up_rack: go to DONE.
  - otherwise: go to POLL_WAIT for 16 cycles, then back to POLL_RD.
REQ-028 The poll counter SHALL count reads; the read numbered POLL_LIMIT returning 0 SHALL go to ERR.
REQ-029 DONE SHALL assert done for one cycle, then return to IDLE; busy is low in the IDLE cycle.
REQ-030 ERR SHALL set error, then return to IDLE after one cycle.
REQ-031 start while busy SHALL be ignored.
REQ-032 An acknowledge arriving while no request is outstanding SHALL be ignored.
REQ-033 up_waddr, up_raddr and up_wdata SHALL hold their values from the request cycle until the acknowledge.

Reset
REQ-034 up_rstn=0 SHALL asynchronously force IDLE and clear every register.
REQ-035 During reset, busy, done, error, up_wreq and up_rreq SHALL be 0, and address and data outputs SHALL be 0.
REQ-036 Reset during a sequence SHALL abort it with no further bus requests; an outstanding acknowledge after reset is discarded.

Configuration
REQ-037 Macro TPL_ADC_CFG_SEQ_READBACK_EN, when defined, SHALL add state PROF_RD after PROF_WR.
  - PROF_RD reads PROFILE_ADDR.
  - Data matching the latched profile proceeds to RST_RELEASE; a mismatch goes to ERR.
REQ-038 Without TPL_ADC_CFG_SEQ_READBACK_EN, PROF_WR SHALL go directly to RST_RELEASE, and no PROF_RD logic SHALL exist.

Verification
REQ-039 NUM_PROFILES=2, start with profile=1; responder acks every request after 2 cycles; status read returns 1 on the first poll.
  - Required: writes (0x010,0x0), (0x090,0x1), (0x010,0x3) in order, one read of 0x017, one done pulse, error=0.
REQ-040 Status returns 0 for 3 reads, then 1.
  - Required: 4 reads of 0x017, each pair separated by 16 idle cycles, then done.
REQ-041 POLL_LIMIT=4, status always 0.
  - Required: exactly 4 reads, then error=1, no done, busy=0.
REQ-042 profile=2 with NUM_PROFILES=2.
  - Required: error=1, zero up_wreq/up_rreq pulses.
REQ-043 Responder withholds up_wack on the second write.
  - Required: error asserted ACK_LIMIT cycles after that request.
  - A further start issued while busy produces no new sequence.
REQ-044 up_rstn pulsed low during POLL_WAIT, then start.
  - Required: all outputs 0 during reset, then a full fresh sequence completes with done.
  - With READBACK_EN and readback data 0x0 for profile 1: error=1 and no RST_RELEASE write.
